// File: rtl/layer_blit_sequencer_pkg.sv
// Shared types for the layer blit sequencer: FSM states, layer kinds and the descriptor layout.
// layer_desc_t is the descriptor at the default parameter set; desc_w() gives the width for any set.
package layer_blit_pkg;

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StDone} state_e;
  typedef enum logic {KindSprite, KindDigit} kind_e;

  localparam int unsigned DefNumLayers = 16;
  localparam int unsigned DefCoordW    = 10;
  localparam int unsigned DefNumValues = 8;
  localparam int unsigned DefValW      = 8;
  localparam int unsigned DefDigits    = 2;
  localparam int unsigned DefGlyphW    = 5;

  // Index width that stays at least one bit for single-entry selections.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned desc_w(input int unsigned coord_w, input int unsigned num_values,
                                         input int unsigned digits);
    return 2 + sel_w(num_values) + sel_w(digits) + 6 * coord_w;
  endfunction

  typedef struct packed {
    logic                           en;
    kind_e                          kind;
    logic [sel_w(DefNumValues)-1:0] val_sel;
    logic [sel_w(DefDigits)-1:0]    digit_pos;
    logic [DefCoordW-1:0]           src_x0;
    logic [DefCoordW-1:0]           src_y0;
    logic [DefCoordW-1:0]           src_x1;
    logic [DefCoordW-1:0]           src_y1;
    logic [DefCoordW-1:0]           dst_x;
    logic [DefCoordW-1:0]           dst_y;
  } layer_desc_t;

endpackage

// File: rtl/layer_blit_sequencer_digit_select.sv
// Picks one decimal digit of a live value: saturate to the displayable range, then
// divide by the selected power of ten and take the remainder mod 10.
module digit_select #(
  parameter int unsigned ValW   = 8,
  parameter int unsigned Digits = 2,
  parameter int unsigned PosW   = 1
) (
  input  logic [ValW-1:0] value_i,
  input  logic [PosW-1:0] digit_pos_i,
  output logic [3:0]      digit_o
);

  localparam int unsigned MaxVal = 10 ** Digits - 1;

  logic [31:0] sat;

  // Each position divides by a constant, so the loop unrolls into fixed dividers plus a mux.
  always_comb begin
    sat     = (32'(value_i) > MaxVal) ? MaxVal : 32'(value_i);
    digit_o = '0;
    for (int unsigned p = 0; p < Digits; p++) begin
      if (32'(digit_pos_i) == p) digit_o = 4'((sat / (10 ** p)) % 10);
    end
  end

endmodule

// File: rtl/layer_blit_sequencer.sv
// Walks a writable layer descriptor table once per frame, issuing one blit command per enabled
// layer and waiting for blit_done. Define LBS_OVERRUN_CNT_EN to add the overrun_cnt port.
module layer_blit_sequencer
  import layer_blit_pkg::*;
#(
  parameter int unsigned NumLayers = 16,
  parameter int unsigned CoordW    = 10,
  parameter int unsigned NumValues = 8,
  parameter int unsigned ValW      = 8,
  parameter int unsigned Digits    = 2,
  parameter int unsigned GlyphW    = 5,
  localparam int unsigned IdxW     = $clog2(NumLayers),
  localparam int unsigned DescW    = desc_w(CoordW, NumValues, Digits)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [IdxW-1:0]           cfg_addr,
  input  logic [DescW-1:0]          cfg_wdata,
  input  logic [NumValues*ValW-1:0] values,
  input  logic                      frame_start,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [CoordW-1:0]         cmd_src_x0,
  output logic [CoordW-1:0]         cmd_src_y0,
  output logic [CoordW-1:0]         cmd_src_x1,
  output logic [CoordW-1:0]         cmd_src_y1,
  output logic [CoordW-1:0]         cmd_dst_x,
  output logic [CoordW-1:0]         cmd_dst_y,
  input  logic                      blit_done,
  output logic                      busy,
  output logic                      frame_done
`ifdef LBS_OVERRUN_CNT_EN
  ,
  output logic [7:0]                overrun_cnt
`endif
);

  localparam int unsigned SelW = sel_w(NumValues);
  localparam int unsigned PosW = sel_w(Digits);

  typedef struct packed {
    logic              en;
    kind_e             kind;
    logic [SelW-1:0]   val_sel;
    logic [PosW-1:0]   digit_pos;
    logic [CoordW-1:0] src_x0;
    logic [CoordW-1:0] src_y0;
    logic [CoordW-1:0] src_x1;
    logic [CoordW-1:0] src_y1;
    logic [CoordW-1:0] dst_x;
    logic [CoordW-1:0] dst_y;
  } desc_t;

  desc_t             table_q [NumLayers];
  logic [ValW-1:0]   snap_q  [NumValues];
  state_e            state_q;
  logic [IdxW-1:0]   idx_q;

  desc_t             cur;
  logic [3:0]        digit;
  logic [CoordW-1:0] x_off;
  logic              last_idx;

  assign cur      = table_q[idx_q];
  assign last_idx = (idx_q == IdxW'(NumLayers - 1));
  assign busy     = (state_q != StIdle);
  assign x_off    = (cur.kind == KindDigit) ? CoordW'(32'(digit) * GlyphW) : '0;

  digit_select #(
    .ValW   (ValW),
    .Digits (Digits),
    .PosW   (PosW)
  ) u_digit_select (
    .value_i     (snap_q[cur.val_sel]),
    .digit_pos_i (cur.digit_pos),
    .digit_o     (digit)
  );

  // The FETCH read of table_q sees the pre-write entry when cfg_we hits the same index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cmd_valid  <= 1'b0;
      cmd_src_x0 <= '0;
      cmd_src_y0 <= '0;
      cmd_src_x1 <= '0;
      cmd_src_y1 <= '0;
      cmd_dst_x  <= '0;
      cmd_dst_y  <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < NumLayers; i++) table_q[i] <= '0;
      for (int k = 0; k < NumValues; k++) snap_q[k] <= '0;
    end else begin
      if (cfg_we) table_q[cfg_addr] <= cfg_wdata;
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q <= StFetch;
            for (int k = 0; k < NumValues; k++) snap_q[k] <= values[k*ValW +: ValW];
          end
        end
        StFetch: begin
          if (cur.en) begin
            cmd_src_x0 <= cur.src_x0 + x_off;
            cmd_src_y0 <= cur.src_y0;
            cmd_src_x1 <= cur.src_x1 + x_off;
            cmd_src_y1 <= cur.src_y1;
            cmd_dst_x  <= cur.dst_x;
            cmd_dst_y  <= cur.dst_y;
            cmd_valid  <= 1'b1;
            state_q    <= StIssue;
          end else if (last_idx) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StIssue: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (blit_done) begin
            if (last_idx) begin
              frame_done <= 1'b1;
              state_q    <= StDone;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LBS_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (frame_start && busy && (overrun_cnt != 8'hff)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule
